// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and types for fifo_flex.
//   count_width(size) - bits needed to hold 0..size
//   fifo_status_t     - occupancy flags and counts bundled for parents that
//                       want to pass FIFO status around as one signal
package fifo_pkg;

  localparam int STATUS_CW = 16;

  function automatic int count_width(input int size);
    return $clog2(size + 1);
  endfunction

  typedef struct packed {
    logic                 empty;
    logic                 full;
    logic                 almost_empty;
    logic                 almost_full;
    logic [STATUS_CW-1:0] num_used;
    logic [STATUS_CW-1:0] num_free;
  } fifo_status_t;

endpackage

// File: rtl/fifo_flex_ram.sv
// fifo_flex_ram: register array with one write port and two asynchronous
// read ports (head and head+1), so the FWFT output can be refreshed in the
// same cycle that the head is popped.
//   clk        clock
//   we_i       write enable
//   waddr_i    write address
//   wdata_i    write data
//   raddr_i    head address
//   rdata0_o   word at raddr_i
//   rdata1_o   word at raddr_i+1 (mod SIZE)
module fifo_flex_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 16,
  parameter int AW         = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o
);

  logic [DATA_WIDTH-1:0] mem_q [SIZE];
  logic [AW-1:0]         raddr_nxt;

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign raddr_nxt = (raddr_i == AW'(SIZE - 1)) ? '0 : raddr_i + AW'(1);
  assign rdata0_o  = mem_q[raddr_i];
  assign rdata1_o  = mem_q[raddr_nxt];

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO of any depth with FWFT or registered-pop
// read mode, threshold flags, synchronous flush and sticky error flags.
//   clk, reset (async, active-high), flush (sync clear)
//   rden / rddata / rddata_valid / rddone   read side
//   wren / wrdata / wrdone                  write side
//   num_used, num_free, empty, full, almost_empty, almost_full  status
//   overflow, underflow (sticky), err_clr
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int SIZE         = 16,
  parameter int FWFT         = 1,
  parameter int AFULL_LEVEL  = SIZE - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          rden,
  output logic [DATA_WIDTH-1:0]         rddata,
  output logic                          rddata_valid,
  output logic                          rddone,
  input  logic                          wren,
  input  logic [DATA_WIDTH-1:0]         wrdata,
  output logic                          wrdone,
  output logic [count_width(SIZE)-1:0]  num_used,
  output logic [count_width(SIZE)-1:0]  num_free,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          err_clr
);

  localparam int CW = count_width(SIZE);
  localparam int AW = $clog2(SIZE);

  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] rddata_q, rddata_d;
  logic                  valid_q, valid_d;
  logic                  rddone_q, wrdone_q;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  rd_acc, wr_acc, rd_fire, wr_fire;
  logic [DATA_WIDTH-1:0] ram_rd0, ram_rd1;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(SIZE - 1)) ? '0 : p + AW'(1);
  endfunction

  fifo_flex_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE       (SIZE),
    .AW         (AW)
  ) u_ram (
    .clk      (clk),
    .we_i     (wr_fire),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (wrdata),
    .raddr_i  (rd_ptr_q),
    .rdata0_o (ram_rd0),
    .rdata1_o (ram_rd1)
  );

  always_comb begin
    // A full FIFO still accepts a write when a pop frees a slot on the same edge.
    rd_acc  = rden && (count_q != '0);
    wr_acc  = wren && ((count_q != CW'(SIZE)) || rd_acc);
    rd_fire = rd_acc && !flush;
    wr_fire = wr_acc && !flush;

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
      if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
    end

    rddata_d = rddata_q;
    if (FWFT != 0) begin
      valid_d = (count_d != '0);
      if (!flush) begin
        // With one word left, the new head (if any) is the word written on
        // this edge, which is not yet in the array.
        if (rd_acc && count_d != '0)
          rddata_d = (count_q == CW'(1)) ? wrdata : ram_rd1;
        else if (count_q == '0 && wr_acc)
          rddata_d = wrdata;
      end
    end else begin
      valid_d = rd_fire;
      if (rd_fire) rddata_d = ram_rd0;
    end

    ovf_d = (ovf_q && !err_clr) || (!flush && wren && !wr_acc);
    udf_d = (udf_q && !err_clr) || (!flush && rden && !rd_acc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rddata_q <= '0;
      valid_q  <= 1'b0;
      rddone_q <= 1'b0;
      wrdone_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rddata_q <= rddata_d;
      valid_q  <= valid_d;
      rddone_q <= rd_fire;
      wrdone_q <= wr_fire;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign rddata       = rddata_q;
  assign rddata_valid = valid_q;
  assign rddone       = rddone_q;
  assign wrdone       = wrdone_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign num_used     = count_q;
  assign num_free     = CW'(SIZE) - count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(SIZE));
  assign almost_full  = (count_q >= CW'(AFULL_LEVEL));
  assign almost_empty = (count_q <= CW'(AEMPTY_LEVEL));

endmodule
